// File: rtl/data_mem_responder.sv
// Fixed-latency word-addressed data memory answering the CPU's READ/WRITE/BUSYWAIT handshake.
// Optional access-fault checking is enabled by defining DMEM_BOUNDS_CHECK_EN.
module data_mem_responder #(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 5
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        READ,
    input  logic        WRITE,
    input  logic [31:0] ADDRESS,
    input  logic [31:0] WRITEDATA,
    output logic [31:0] READDATA,
    output logic        BUSYWAIT,
    output logic        ERROR
);

    localparam int DATA_W = 32;
    localparam int DEPTH  = 2 ** ADDR_WIDTH;
    // The request cycle counts as the first busy cycle, so BUSY ends one count early.
    localparam logic [3:0] LAST_COUNT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t                  state, state_nxt;
    logic [3:0]              count, count_nxt;
    logic                    req;
    logic                    fault;
    logic                    commit;
    logic [ADDR_WIDTH-1:0]   idx;
    logic [DATA_W-1:0]       mem [0:DEPTH-1];

    assign req = READ | WRITE;
    assign idx = ADDRESS[ADDR_WIDTH+1:2];

`ifdef DMEM_BOUNDS_CHECK_EN
    assign fault = (ADDRESS[1:0] != 2'b00) || (ADDRESS[31:ADDR_WIDTH+2] != '0);
`else
    logic unused_addr_bits;
    assign unused_addr_bits = ^{ADDRESS[31:ADDR_WIDTH+2], ADDRESS[1:0]};
    assign fault            = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        BUSYWAIT  = 1'b0;
        commit    = 1'b0;
        case (state)
            IDLE: begin
                BUSYWAIT = req;
                if (req) begin
                    if (fault) begin
                        // Faulting accesses skip the latency and finish after the request cycle.
                        state_nxt = DONE;
                        commit    = 1'b1;
                        count_nxt = 4'd0;
                    end else begin
                        state_nxt = BUSY;
                        count_nxt = 4'd1;
                    end
                end
            end
            BUSY: begin
                BUSYWAIT = 1'b1;
                if (!req) begin
                    state_nxt = IDLE;
                    count_nxt = 4'd0;
                end else if (count >= LAST_COUNT) begin
                    state_nxt = DONE;
                    commit    = 1'b1;
                    count_nxt = 4'd0;
                end else begin
                    count_nxt = count + 4'd1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                count_nxt = 4'd0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state    <= IDLE;
            count    <= 4'd0;
            READDATA <= '0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
            // A simultaneous READ and WRITE is a write and leaves READDATA alone.
            if (commit && READ && !WRITE) begin
                READDATA <= fault ? 32'hDEAD_BEEF : mem[idx];
            end
        end
    end

`ifdef DMEM_BOUNDS_CHECK_EN
    always_ff @(posedge CLK) begin
        if (RESET) begin
            ERROR <= 1'b0;
        end else begin
            ERROR <= commit && fault;
        end
    end
`else
    assign ERROR = 1'b0;
`endif

    // Array has no reset; a reset edge simply suppresses any pending commit.
    always_ff @(posedge CLK) begin
        if (!RESET && commit && WRITE && !fault) begin
            mem[idx] <= WRITEDATA;
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized self-checking bench for data_mem_responder against a transaction-level memory model.
// Honours DMEM_BOUNDS_CHECK_EN the same way the design does.
module tb_data_mem_responder;

    localparam int ADDR_W = 10;
    localparam int LAT    = 5;
    localparam int POOL   = 16;

    logic        CLK;
    logic        RESET;
    logic        READ;
    logic        WRITE;
    logic [31:0] ADDRESS;
    logic [31:0] WRITEDATA;
    logic [31:0] READDATA;
    logic        BUSYWAIT;
    logic        ERROR;

    int          n_vec;
    int          n_err;
    logic [31:0] ref_mem [int];
    logic [31:0] exp_rd;

    data_mem_responder #(
        .ADDR_WIDTH(ADDR_W),
        .LATENCY   (LAT)
    ) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .READ     (READ),
        .WRITE    (WRITE),
        .ADDRESS  (ADDRESS),
        .WRITEDATA(WRITEDATA),
        .READDATA (READDATA),
        .BUSYWAIT (BUSYWAIT),
        .ERROR    (ERROR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic is_fault(input logic [31:0] addr);
`ifdef DMEM_BOUNDS_CHECK_EN
        return (addr[1:0] != 2'b00) || ((addr >> (ADDR_W + 2)) != 0);
`else
        return 1'b0;
`endif
    endfunction

    function automatic int word_of(input logic [31:0] addr);
        return int'((addr >> 2) % (1 << ADDR_W));
    endfunction

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            check("idle_busywait", 32'(BUSYWAIT), 32'd0);
            next_cycle();
        end
    endtask

    // Complete access: BUSYWAIT for the expected busy length, then one DONE cycle.
    task automatic access(input logic rd, input logic wr, input logic [31:0] addr, input logic [31:0] data);
        logic flt;
        int   busy;
        flt  = is_fault(addr);
        busy = flt ? 1 : LAT;
        READ = rd; WRITE = wr; ADDRESS = addr; WRITEDATA = data;
        for (int i = 0; i < busy; i++) begin
            @(negedge CLK);
            check("busywait_hi", 32'(BUSYWAIT), 32'd1);
            next_cycle();
        end
        if (wr) begin
            if (!flt) ref_mem[word_of(addr)] = data;
        end else begin
            exp_rd = flt ? 32'hDEAD_BEEF : ref_mem[word_of(addr)];
        end
        READ = 1'b0; WRITE = 1'b0;
        @(negedge CLK);
        check("busywait_done", 32'(BUSYWAIT), 32'd0);
        check("readdata", READDATA, exp_rd);
        check("error", 32'(ERROR), 32'(flt));
        next_cycle();
    endtask

    // Request withdrawn while still busy: nothing commits.
    task automatic abort_access(input logic rd, input logic wr, input logic [31:0] addr, input int drop_cycle);
        READ = rd; WRITE = wr; ADDRESS = addr; WRITEDATA = $urandom;
        for (int i = 1; i < drop_cycle; i++) begin
            @(negedge CLK);
            check("abort_busywait_hi", 32'(BUSYWAIT), 32'd1);
            next_cycle();
        end
        READ = 1'b0; WRITE = 1'b0;
        next_cycle();
        @(negedge CLK);
        check("abort_busywait_lo", 32'(BUSYWAIT), 32'd0);
        check("abort_readdata", READDATA, exp_rd);
        check("abort_error", 32'(ERROR), 32'd0);
        next_cycle();
    endtask

    // Reset lands in busy cycle 3 of a write; the write must be lost.
    task automatic reset_mid_write(input logic [31:0] addr, input logic [31:0] data);
        READ = 1'b0; WRITE = 1'b1; ADDRESS = addr; WRITEDATA = data;
        for (int i = 1; i < 3; i++) begin
            @(negedge CLK);
            check("rst_busywait_hi", 32'(BUSYWAIT), 32'd1);
            next_cycle();
        end
        RESET = 1'b1;
        next_cycle();
        RESET = 1'b0; WRITE = 1'b0;
        exp_rd = 32'd0;
        @(negedge CLK);
        check("rst_busywait_lo", 32'(BUSYWAIT), 32'd0);
        check("rst_readdata", READDATA, 32'd0);
        check("rst_error", 32'(ERROR), 32'd0);
        next_cycle();
    endtask

    function automatic logic [31:0] rand_addr(input int w);
        logic [31:0] a;
`ifdef DMEM_BOUNDS_CHECK_EN
        a = 32'(w) << 2;
`else
        a = ($urandom & ~((32'd1 << (ADDR_W + 2)) - 1)) | (32'(w) << 2) | ($urandom & 32'd3);
`endif
        return a;
    endfunction

    initial begin
        n_vec = 0; n_err = 0;
        RESET = 1'b1; READ = 1'b0; WRITE = 1'b0; ADDRESS = '0; WRITEDATA = '0;
        exp_rd = 32'd0;

        // T1 reset
        repeat (2) @(posedge CLK);
        #1 RESET = 1'b0;
        @(negedge CLK);
        check("reset_readdata", READDATA, 32'd0);
        check("reset_busywait", 32'(BUSYWAIT), 32'd0);
        check("reset_error", 32'(ERROR), 32'd0);
        next_cycle();

        // Seed a pool of words; word 12 (0x30) holds zero so the post-reset read is defined.
        for (int w = 0; w < POOL; w++) begin
            access(1'b0, 1'b1, 32'(w) << 2, (w == 12) ? 32'd0 : $urandom);
        end

        // T2 write then read
        access(1'b0, 1'b1, 32'h10, 32'hCAFE_F00D);
        idle_cycles(1);
        access(1'b1, 1'b0, 32'h10, 32'h0);

        // T3 back-to-back, with the read issued the cycle after DONE
        access(1'b0, 1'b1, 32'h20, 32'h1234_5678);
        access(1'b1, 1'b0, 32'h20, 32'h0);

        // T4 reset mid-write, then read back the untouched word
        reset_mid_write(32'h30, 32'hFFFF_FFFF);
        access(1'b1, 1'b0, 32'h30, 32'h0);

        // T5 abort a read, then a write, and confirm the write never landed
        abort_access(1'b1, 1'b0, 32'h40, 2);
        abort_access(1'b0, 1'b1, 32'h44, 3);
        access(1'b1, 1'b0, 32'h44, 32'h0);

        // T6 out-of-range / misaligned address
        access(1'b1, 1'b0, 32'h0000_1002, 32'h0);

        // Both READ and WRITE: a write that leaves READDATA alone
        access(1'b1, 1'b1, 32'h14, 32'hA5A5_0F0F);
        access(1'b1, 1'b0, 32'h14, 32'h0);

        // Randomized traffic
        for (int n = 0; n < 60; n++) begin
            int op;
            int w;
            op = int'($urandom_range(0, 4));
            w  = int'($urandom_range(0, POOL - 1));
            case (op)
                0:       access(1'b0, 1'b1, rand_addr(w), $urandom);
                1, 2:    access(1'b1, 1'b0, rand_addr(w), 32'h0);
                3:       access(1'b1, 1'b1, rand_addr(w), $urandom);
                default: abort_access(1'($urandom_range(0, 1)), 1'b1, rand_addr(w), int'($urandom_range(2, LAT)));
            endcase
            idle_cycles(int'($urandom_range(0, 2)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
